// File: rtl/color_sense_frontend.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// color_sense_frontend
//
// Front end for a TCS3200-class colour sensor, feeding led_logic.
// The block steps the sensor filter through R, G and B. For each filter it
// waits a settle window and then counts sensor_out rising edges over a fixed
// gate window. At the end of the frame it picks the dominant channel, passes
// the result through a debounce, and publishes the debounced colour.
//
// Ports
//   clk_1MHz   in   system clock
//   rst        in   synchronous active-high reset; has priority over en
//   en         in   1 = run frames back to back, 0 = abort the frame and idle
//   sensor_out in   asynchronous sensor frequency output
//   s2, s3     out  filter select; {s2,s3}: R=00, G=11, B=01, 00 when idle
//   color      out  debounced colour: 0 none, 1 red, 2 green, 3 blue
//   frame_done out  1-cycle pulse at the end of every completed frame
//   dbg_state  out  current FSM state (IDLE=0, SETTLE=1, COUNT=2, DECIDE=3)
//
// Output protocol: frame_done is a valid-only strobe with no ready. It is
// high for exactly one cycle, the DECIDE cycle, and color already carries
// that frame's debounced result in the same cycle. color is a held register
// and changes only in a cycle where frame_done is high. A sink that misses
// the strobe can still read the held colour at any time.
// -----------------------------------------------------------------------------
module color_sense_frontend #(
  parameter int GATE_CYCLES   = 10000,
  parameter int SETTLE_CYCLES = 100,
  parameter int CNT_W         = 16,
  parameter int MIN_COUNT     = 50,
  parameter int STABLE_N      = 3
) (
  input  logic       clk_1MHz,
  input  logic       rst,
  input  logic       en,
  input  logic       sensor_out,
  output logic       s2,
  output logic       s3,
  output logic [1:0] color,
  output logic       frame_done,
  output logic [1:0] dbg_state
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int STB_W   = $clog2(STABLE_N + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ALL1    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C       = CNT_W'(MIN_COUNT);
  localparam logic [STB_W-1:0] STB_FULL    = STB_W'(STABLE_N);
  localparam logic [STB_W-1:0] STB_ONE     = STB_W'(1);

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DECIDE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchroniser, a delayed copy for edge detection, and a
  // registered rising-edge pulse. The counters only ever see edge_q.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic edge_q,  edge_d;

  always_comb begin
    sync1_d = sensor_out;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    edge_d  = sync2_q & ~sync3_q;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, gate timer and channel counters
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [1:0]       chan_q, chan_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_r_q, cnt_r_d;
  logic [CNT_W-1:0] cnt_g_q, cnt_g_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic [1:0]       sel_q, sel_d;
  logic             decide_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_ALL1) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    tmr_d      = tmr_q;
    cnt_r_d    = cnt_r_q;
    cnt_g_d    = cnt_g_q;
    cnt_b_d    = cnt_b_q;
    decide_now = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SETTLE;
          chan_d  = CH_R;
          tmr_d   = '0;
          cnt_r_d = '0;
        end
      end

      ST_SETTLE: begin
        // Edges arriving while the filter settles are ignored.
        if (!en) begin
          state_d = ST_IDLE;
        end else if (tmr_q == SETTLE_LAST) begin
          state_d = ST_COUNT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end

      ST_COUNT: begin
        if (edge_q) begin
          case (chan_q)
            CH_R:    cnt_r_d = sat_inc(cnt_r_q);
            CH_G:    cnt_g_d = sat_inc(cnt_g_q);
            default: cnt_b_d = sat_inc(cnt_b_q);
          endcase
        end
        if (!en) begin
          state_d = ST_IDLE;
        end else if (tmr_q == GATE_LAST) begin
          tmr_d = '0;
          if (chan_q == CH_B) begin
            // The decision is taken on this edge, using the blue count that
            // includes the final gate cycle. The result is therefore already
            // registered in the DECIDE cycle, which is when frame_done is high.
            state_d    = ST_DECIDE;
            decide_now = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            if (chan_q == CH_R) begin
              chan_d  = CH_G;
              cnt_g_d = '0;
            end else begin
              chan_d  = CH_B;
              cnt_b_d = '0;
            end
          end
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end

      ST_DECIDE: begin
        if (en) begin
          state_d = ST_SETTLE;
          chan_d  = CH_R;
          tmr_d   = '0;
          cnt_r_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The filter select is registered from the next state, so it changes on the
  // same edge that enters SETTLE and has no glitches toward the sensor.
  always_comb begin
    sel_d = 2'b00;
    if (state_d == ST_SETTLE || state_d == ST_COUNT) begin
      case (chan_d)
        CH_G:    sel_d = 2'b11;
        CH_B:    sel_d = 2'b01;
        default: sel_d = 2'b00;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Classification and debounce
  // ---------------------------------------------------------------------------
  logic [1:0]       cand;
  logic [1:0]       last_cand_q, last_cand_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [1:0]       color_q, color_d;
  logic             frame_done_q, frame_done_d;

  // Any tie for the maximum, or a winner below MIN_COUNT, means "no colour".
  always_comb begin
    cand = 2'd0;
    if (cnt_r_d > cnt_g_d && cnt_r_d > cnt_b_d && cnt_r_d >= MIN_C) begin
      cand = 2'd1;
    end else if (cnt_g_d > cnt_r_d && cnt_g_d > cnt_b_d && cnt_g_d >= MIN_C) begin
      cand = 2'd2;
    end else if (cnt_b_d > cnt_r_d && cnt_b_d > cnt_g_d && cnt_b_d >= MIN_C) begin
      cand = 2'd3;
    end
  end

  always_comb begin
    last_cand_d  = last_cand_q;
    stable_d     = stable_q;
    color_d      = color_q;
    frame_done_d = decide_now;
    if (decide_now) begin
      if (cand == last_cand_q) begin
        stable_d = (stable_q == STB_FULL) ? stable_q : stable_q + STB_ONE;
      end else begin
        stable_d    = STB_ONE;
        last_cand_d = cand;
      end
      if (stable_d == STB_FULL) begin
        color_d = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      edge_q       <= 1'b0;
      state_q      <= ST_IDLE;
      chan_q       <= CH_R;
      tmr_q        <= '0;
      cnt_r_q      <= '0;
      cnt_g_q      <= '0;
      cnt_b_q      <= '0;
      sel_q        <= 2'b00;
      last_cand_q  <= 2'd0;
      stable_q     <= '0;
      color_q      <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      edge_q       <= edge_d;
      state_q      <= state_d;
      chan_q       <= chan_d;
      tmr_q        <= tmr_d;
      cnt_r_q      <= cnt_r_d;
      cnt_g_q      <= cnt_g_d;
      cnt_b_q      <= cnt_b_d;
      sel_q        <= sel_d;
      last_cand_q  <= last_cand_d;
      stable_q     <= stable_d;
      color_q      <= color_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s2         = sel_q[1];
  assign s3         = sel_q[0];
  assign color      = color_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_color_sense_frontend.sv
`timescale 1ns/1ps
// Bench for color_sense_frontend with GATE=100, SETTLE=4, MIN_COUNT=10 and
// STABLE_N=2. CNT_W is 5 (saturates at 31) so that saturation can be reached
// inside a 100-cycle gate: the edge detector accepts at most one edge every
// two cycles.
// Stimulus acts like the sensor: it watches which gate window is open and
// emits a directed number of edges into it. Each frame pushes its
// hand-computed expected colour. The monitor pops one entry per frame_done.
module tb_color_sense_frontend;

  logic       clk_1MHz = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sensor_out = 1'b0;
  logic       s2, s3;
  logic [1:0] color;
  logic       frame_done;
  logic [1:0] dbg_state;

  color_sense_frontend #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(5), .MIN_COUNT(10), .STABLE_N(2)
  ) dut (
    .clk_1MHz(clk_1MHz), .rst(rst), .en(en), .sensor_out(sensor_out),
    .s2(s2), .s3(s3), .color(color), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_1MHz = ~clk_1MHz;

  int cyc = 0;
  always @(posedge clk_1MHz) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad = 0;
  logic [1:0] exp_q[$];
  int         fd_cyc_q[$];
  int         n_push = 0;
  int         n_fd = 0;
  int         rst_rel = 0;
  logic [1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_1MHz) begin
    if (!rst && frame_done === 1'b1) begin
      n_fd++;
      fd_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame_done: got frame_done=1 expected none (t=%0t)", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("color_at_frame_done", color, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Wait for the next entry into COUNT (leaving the current one first).
  task automatic wait_count_enter(output bit ok);
    int n = 0;
    while (dbg_state == 2'd2 && n < 600) begin @(negedge clk_1MHz); n++; end
    while (dbg_state != 2'd2 && n < 600) begin @(negedge clk_1MHz); n++; end
    ok = (dbg_state == 2'd2);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_count: got state=%0d expected 2 within 600 cycles", dbg_state);
    end
  endtask

  task automatic drive_edges(input int n, input bit async_mode);
    if (!async_mode) begin
      repeat (n) begin
        sensor_out = 1'b1; @(negedge clk_1MHz);
        sensor_out = 1'b0; @(negedge clk_1MHz);
      end
    end else begin
      #($urandom_range(1, 9));
      repeat (n) begin
        sensor_out = 1'b1; #($urandom_range(20, 29));
        sensor_out = 1'b0; #($urandom_range(20, 29));
      end
      @(negedge clk_1MHz);
    end
  endtask

  task automatic run_frame(input int r, input int g, input int b,
                           input bit async_mode, input logic [1:0] exp);
    int         cnts[3];
    logic [1:0] sels[3];
    bit         ok;
    cnts = '{r, g, b};
    sels = '{2'b00, 2'b11, 2'b01};
    exp_q.push_back(exp);
    n_push++;
    for (int ch = 0; ch < 3; ch++) begin
      wait_count_enter(ok);
      if (ok) begin
        check($sformatf("sel_ch%0d", ch), {s2, s3}, sels[ch]);
        drive_edges(cnts[ch], async_mode);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  bit ok_main;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk_1MHz);
    @(negedge clk_1MHz);
    check("rst_color", color, 0);
    check("rst_sel", {s2, s3}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    rst_rel = cyc;

    // Red patch: first frame arms the debounce, second publishes red.
    run_frame(25, 5, 5, 1'b0, 2'd0);
    run_frame(25, 5, 5, 1'b0, 2'd1);
    // Tie R=G: candidate 0, colour held at red.
    run_frame(25, 25, 5, 1'b0, 2'd1);

    check("fd_seen_after_two", (fd_cyc_q.size() >= 2), 1);
    if (fd_cyc_q.size() >= 2) begin
      check("first_fd_latency", fd_cyc_q[0] - rst_rel, 313);
      check("frame_length", fd_cyc_q[1] - fd_cyc_q[0], 313);
    end

    // Abort in the middle of COUNT(G).
    wait_count_enter(ok_main);
    drive_edges(5, 1'b0);
    wait_count_enter(ok_main);
    check("abort_sel_g", {s2, s3}, 2'b11);
    drive_edges(3, 1'b0);
    en = 1'b0;
    @(negedge clk_1MHz);
    check("abort_state_idle", dbg_state, 0);
    check("abort_sel_idle", {s2, s3}, 0);
    check("abort_color_hold", color, 1);
    repeat (20) @(negedge clk_1MHz);
    check("abort_color_hold_later", color, 1);
    en = 1'b1;
    @(negedge clk_1MHz);
    check("restart_state_settle", dbg_state, 1);
    check("restart_sel_red", {s2, s3}, 0);

    // Asynchronous-phase edges, blue dominant (exactly 12 >= 10).
    run_frame(3, 4, 12, 1'b1, 2'd1);
    run_frame(3, 4, 12, 1'b1, 2'd3);
    // Below threshold twice: blue -> none.
    run_frame(9, 3, 2, 1'b0, 2'd3);
    run_frame(9, 3, 2, 1'b0, 2'd0);
    // Saturation (40 edges -> 31, still red) and red/green alternation.
    run_frame(40, 5, 5, 1'b0, 2'd0);
    run_frame(5, 20, 5, 1'b0, 2'd0);
    run_frame(40, 5, 5, 1'b0, 2'd0);
    run_frame(5, 20, 5, 1'b0, 2'd0);
    // Saturated R=31 ties G=31: candidate 0 (a wrapped R would let green win).
    run_frame(40, 31, 5, 1'b0, 2'd0);
    // Exactly MIN_COUNT qualifies.
    run_frame(10, 3, 3, 1'b0, 2'd0);
    run_frame(10, 3, 3, 1'b0, 2'd1);

    for (int n = 0; n < 800 && exp_q.size() != 0; n++) @(negedge clk_1MHz);
    check("queue_drained", exp_q.size(), 0);
    check("frames_done", n_fd, n_push);

    // Mid-frame reset with en still high.
    repeat (50) @(negedge clk_1MHz);
    rst = 1'b1;
    @(negedge clk_1MHz);
    check("midrst_color", color, 0);
    check("midrst_state", dbg_state, 0);
    check("midrst_sel", {s2, s3}, 0);
    check("midrst_frame_done", frame_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
